wb_rr_arbiter2: RTL

//  Two-master, one-slave Wishbone B3 classic arbiter for picorv32_wb_soc. It shares the SoC slave
//  bus between the CPU data/instr master (m0) and a second master (m1: UART debug loader or DMA).

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_watchdog.sv | 38 +++
 rtl/wb_rr_arbiter2.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM states and default bus widths.
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT0  = 2'd1,
      ST_GNT1  = 2'd2,
      ST_ABORT = 2'd3
   } arb_state_e;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   // Byte-select width for an arbitrary data width.
   function automatic int sel_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles and flags the cycle on
// which the count would reach TIMEOUT. Clear takes priority over increment.
module wb_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: clear on response/idle, otherwise step while the strobe waits.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = inc_i && !clr_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin Wishbone B3 classic arbiter with bus watchdog.
// The grant is held for a whole CYC; muxing is combinational from the
// registered state, so the only latency is one arbitration cycle.
module wb_rr_arbiter2
   import wb_pkg::*;
#(
   parameter int AW      = WB_AW,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   // master 0
   input  logic [AW-1:0]        m0_adr_i,
   input  logic [DW-1:0]        m0_dat_i,
   output logic [DW-1:0]        m0_dat_o,
   input  logic [DW/8-1:0]      m0_sel_i,
   input  logic                 m0_we_i,
   input  logic                 m0_stb_i,
   input  logic                 m0_cyc_i,
   output logic                 m0_ack_o,
   output logic                 m0_err_o,
   output logic                 m0_rty_o,
   // master 1
   input  logic [AW-1:0]        m1_adr_i,
   input  logic [DW-1:0]        m1_dat_i,
   output logic [DW-1:0]        m1_dat_o,
   input  logic [DW/8-1:0]      m1_sel_i,
   input  logic                 m1_we_i,
   input  logic                 m1_stb_i,
   input  logic                 m1_cyc_i,
   output logic                 m1_ack_o,
   output logic                 m1_err_o,
   output logic                 m1_rty_o,
   // slave
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   output logic                 s_we_o,
   output logic                 s_stb_o,
   output logic                 s_cyc_o,
   input  logic [DW-1:0]        s_dat_i,
   input  logic                 s_ack_i,
   input  logic                 s_err_i,
   input  logic                 s_rty_i,
   // status
   output logic [1:0]           grant_o,
   output logic                 timeout_o
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;    // master that owned the bus most recently
   logic       owner_q, owner_d;  // master being served (needed in ABORT)

   logic       wd_inc;
   logic       wd_hit;
   logic       in_gnt;
   logic       cur_stb;
   logic       slv_resp;

   assign in_gnt   = (state_q == ST_GNT0) || (state_q == ST_GNT1);
   assign cur_stb  = (state_q == ST_GNT1) ? m1_stb_i : m0_stb_i;
   assign slv_resp = s_ack_i || s_err_i || s_rty_i;
   assign wd_inc   = in_gnt && cur_stb && !slv_resp;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_wdog (
      .clock   (clock),
      .reset_n (reset_n),
      .clr_i   (!wd_inc),
      .inc_i   (wd_inc),
      .hit_o   (wd_hit)
   );

   // State, round-robin history and current owner registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

   // Next-state: round-robin pick in IDLE, hold while CYC, abort on watchdog.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? ST_GNT0 : ST_GNT1;
               owner_d = !last_q;
            end else if (m0_cyc_i) begin
               state_d = ST_GNT0;
               owner_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d = ST_GNT1;
               owner_d = 1'b1;
            end
         end
         ST_GNT0: begin
            if (!m0_cyc_i) begin
               state_d = ST_IDLE;
               last_d  = 1'b0;
            end else if (wd_hit) begin
               state_d = ST_ABORT;
            end
         end
         ST_GNT1: begin
            if (!m1_cyc_i) begin
               state_d = ST_IDLE;
               last_d  = 1'b1;
            end else if (wd_hit) begin
               state_d = ST_ABORT;
            end
         end
         ST_ABORT: begin
            if (owner_q ? m1_cyc_i : m0_cyc_i) begin
               state_d = owner_q ? ST_GNT1 : ST_GNT0;
            end else begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: slave bus driven by the owner, responses routed only to it.
   always_comb begin
      m0_dat_o  = s_dat_i;
      m1_dat_o  = s_dat_i;
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_sel_o   = m0_sel_i;
      s_we_o    = m0_we_i;
      s_stb_o   = 1'b0;
      s_cyc_o   = 1'b0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m0_rty_o  = 1'b0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      m1_rty_o  = 1'b0;
      grant_o   = 2'b00;
      timeout_o = 1'b0;
      unique case (state_q)
         ST_GNT0: begin
            s_stb_o  = m0_stb_i;
            s_cyc_o  = m0_cyc_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
            m0_rty_o = s_rty_i;
            grant_o  = 2'b01;
         end
         ST_GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_stb_o  = m1_stb_i;
            s_cyc_o  = m1_cyc_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
            m1_rty_o = s_rty_i;
            grant_o  = 2'b10;
         end
         ST_ABORT: begin
            timeout_o = 1'b1;
            m0_err_o  = !owner_q;
            m1_err_o  = owner_q;
         end
         default: ;
      endcase
   end

endmodule
